// File: rtl/pixel_stream_pkg.sv
// Shared types and widths for the pixel capture to AXI-Stream path.
// Imported by the interface, the FIFO user and the top level.
package pixel_stream_pkg;

    localparam int PIXEL_W = 12;
    localparam int BYTE_W  = 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SOF,
        CAPTURE,
        DRAIN
    } state_e;

    typedef struct packed {
        logic               eof;
        logic [PIXEL_W-1:0] pixel;
    } fifo_entry_t;

    localparam int ENTRY_W = $bits(fifo_entry_t);

endpackage

// File: rtl/pixel_stream_tx_if.sv
// AXI-Stream byte channel from the pixel serializer to the DMA S2MM port.
interface pixel_stream_tx_if;
    import pixel_stream_pkg::*;

    logic [BYTE_W-1:0] M_AXIS_DATA;
    logic              M_AXIS_VALID;
    logic              M_AXIS_LAST;
    logic              M_AXIS_READY;

    modport master (
        output M_AXIS_DATA,
        output M_AXIS_VALID,
        output M_AXIS_LAST,
        input  M_AXIS_READY
    );

    modport slave (
        input  M_AXIS_DATA,
        input  M_AXIS_VALID,
        input  M_AXIS_LAST,
        output M_AXIS_READY
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; a write while full is taken when a read
// frees the head slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 13,
    parameter int AW    = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;
    logic [WIDTH-1:0] mem_q [2**AW];
    logic             wr_ok;
    logic             rd_ok;

    assign empty_o   = (wptr_q == rptr_q);
    assign full_o    = (wptr_q[AW] != rptr_q[AW]) &&
                       (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign wr_ok     = wr_en_i && (!full_o || rd_en_i);
    assign rd_ok     = rd_en_i && !empty_o;
    assign rd_data_o = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (wr_ok) wptr_q <= wptr_q + PTR_ONE;
            if (rd_ok) rptr_q <= rptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_ok) mem_q[wptr_q[AW-1:0]] <= wr_data_i;
    end

endmodule

// File: rtl/pixel_stream_tx.sv
// Captures one VGA frame on request and streams it as two bytes per pixel
// over AXI-Stream, with LAST on the high byte of the final pixel.
module pixel_stream_tx
    import pixel_stream_pkg::*;
#(
    parameter int H_ACTIVE        = 640,
    parameter int V_ACTIVE        = 480,
    parameter int FIFO_ADDR_WIDTH = 10
) (
    input  logic               i_CLK,
    input  logic               i_RST,
    input  logic               i_TICK_25,
    input  logic [10:0]        HC,
    input  logic [10:0]        VC,
    input  logic [PIXEL_W-1:0] i_RGB_DATA,
    input  logic               i_CAPTURE_START,
    pixel_stream_tx_if.master  m_axis,
    output logic               o_BUSY,
    output logic               o_FRAME_DONE,
    output logic               o_OVERFLOW
);

    localparam logic [10:0] H_LIM  = 11'(H_ACTIVE);
    localparam logic [10:0] V_LIM  = 11'(V_ACTIVE);
    localparam logic [10:0] H_LAST = 11'(H_ACTIVE - 1);
    localparam logic [10:0] V_LAST = 11'(V_ACTIVE - 1);

    state_e             state_q;
    logic               ovf_q;
    logic               done_q;
    logic               pend_vld_q;
    logic [PIXEL_W-1:0] pend_pix_q;
    logic               hold_vld_q;
    logic               hold_hi_q;
    logic               hold_eof_q;
    logic [PIXEL_W-1:0] hold_pix_q;

    fifo_entry_t wr_ent;
    fifo_entry_t head;
    logic        fifo_wr;
    logic        fifo_rd;
    logic        fifo_full;
    logic        fifo_empty;
    logic        active;
    logic        is_eof;
    logic        cap;
    logic        can_wr;
    logic        xfer;
    logic        last;

    assign active = i_TICK_25 && (HC < H_LIM) && (VC < V_LIM);
    assign is_eof = (HC == H_LAST) && (VC == V_LAST);
    assign cap    = active &&
                    ((state_q == WAIT_SOF && HC == '0 && VC == '0) ||
                     state_q == CAPTURE);

    assign xfer    = hold_vld_q && m_axis.M_AXIS_READY;
    assign last    = hold_vld_q && hold_hi_q && hold_eof_q;
    assign fifo_rd = !fifo_empty && (!hold_vld_q || (xfer && hold_hi_q));
    assign can_wr  = !fifo_full || fifo_rd;

    // The pending eof pixel only exists after capture has ended.
    always_comb begin
        wr_ent  = '{eof: 1'b1, pixel: pend_pix_q};
        fifo_wr = 1'b0;
        if (pend_vld_q) begin
            fifo_wr = can_wr;
        end else if (cap) begin
            wr_ent  = '{eof: is_eof, pixel: i_RGB_DATA};
            fifo_wr = can_wr;
        end
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .AW    (FIFO_ADDR_WIDTH)
    ) u_fifo (
        .clk_i     (i_CLK),
        .rst_i     (i_RST),
        .wr_en_i   (fifo_wr),
        .wr_data_i (wr_ent),
        .rd_en_i   (fifo_rd),
        .rd_data_o (head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state_q    <= IDLE;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
            pend_vld_q <= 1'b0;
            pend_pix_q <= '0;
            hold_vld_q <= 1'b0;
            hold_hi_q  <= 1'b0;
            hold_eof_q <= 1'b0;
            hold_pix_q <= '0;
        end else begin
            done_q <= xfer && last;

            unique case (state_q)
                IDLE: begin
                    if (i_CAPTURE_START) begin
                        state_q <= WAIT_SOF;
                        ovf_q   <= 1'b0;
                    end
                end
                WAIT_SOF: if (cap) state_q <= is_eof ? DRAIN : CAPTURE;
                CAPTURE:  if (cap && is_eof) state_q <= DRAIN;
                DRAIN:    if (xfer && last) state_q <= IDLE;
                default:  state_q <= IDLE;
            endcase

            if (pend_vld_q) begin
                if (can_wr) pend_vld_q <= 1'b0;
            end else if (cap && !can_wr) begin
                if (is_eof) begin
                    pend_vld_q <= 1'b1;
                    pend_pix_q <= i_RGB_DATA;
                end else begin
                    ovf_q <= 1'b1;
                end
            end

            // Reload on the high-byte handshake keeps pixels back-to-back.
            if (fifo_rd) begin
                hold_vld_q <= 1'b1;
                hold_hi_q  <= 1'b0;
                hold_eof_q <= head.eof;
                hold_pix_q <= head.pixel;
            end else if (xfer) begin
                hold_hi_q <= !hold_hi_q;
                if (hold_hi_q) hold_vld_q <= 1'b0;
            end
        end
    end

    always_comb begin
        m_axis.M_AXIS_DATA = '0;
        if (hold_vld_q) begin
            m_axis.M_AXIS_DATA = hold_hi_q ? {4'h0, hold_pix_q[11:8]}
                                           : hold_pix_q[7:0];
        end
    end

    assign m_axis.M_AXIS_VALID = hold_vld_q;
    assign m_axis.M_AXIS_LAST  = last;
    assign o_BUSY              = (state_q != IDLE);
    assign o_FRAME_DONE        = done_q;
    assign o_OVERFLOW          = ovf_q;

endmodule

// File: tb/tb_pixel_stream_tx.sv
// Directed bench for pixel_stream_tx on a reduced 8x4 frame with a 16-deep
// FIFO, using a byte scoreboard fed by a model of the capture window.
module tb_pixel_stream_tx;
    import pixel_stream_pkg::*;

    localparam int H     = 8;
    localparam int V     = 4;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;
    localparam int HT    = 12;
    localparam int VT    = 6;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        tick  = 1'b0;
    logic        start = 1'b0;
    logic [10:0] hc_p  = '0;
    logic [10:0] vc_p  = '0;
    logic [11:0] rgb   = '0;
    logic        busy;
    logic        fdone;
    logic        ovf;

    pixel_stream_tx_if axis();

    pixel_stream_tx #(
        .H_ACTIVE        (H),
        .V_ACTIVE        (V),
        .FIFO_ADDR_WIDTH (AW)
    ) dut (
        .i_CLK           (clk),
        .i_RST           (rst),
        .i_TICK_25       (tick),
        .HC              (hc_p),
        .VC              (vc_p),
        .i_RGB_DATA      (rgb),
        .i_CAPTURE_START (start),
        .m_axis          (axis),
        .o_BUSY          (busy),
        .o_FRAME_DONE    (fdone),
        .o_OVERFLOW      (ovf)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;
    logic [8:0] sb [$];
    int ms = 0;
    int ph = 0;
    int hcnt = 0;
    int vcnt = 0;
    int rmode = 1;
    bit ovf_mode = 0;
    int acc = 0;
    int nbytes = 0;
    int nlast = 0;
    int ndone = 0;
    logic [7:0] first_b = '0;
    logic prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    logic prev_last = 1'b0;

    function automatic logic [11:0] pix_of(input int x, input int y);
        int idx;
        idx = y * H + x;
        if (idx == 0) return 12'hA5C;
        return 12'(idx * 37 - 36);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock of stimulus; the model decides which pixels get captured.
    task automatic cycle(input bit st);
        logic [11:0] p;
        bit eof;
        @(posedge clk);
        #1;
        start = st;
        tick  = 1'b0;
        case (rmode)
            0:       axis.M_AXIS_READY = 1'b0;
            1:       axis.M_AXIS_READY = 1'b1;
            default: axis.M_AXIS_READY = ($urandom_range(0, 99) >= 30);
        endcase
        ph = ph + 1;
        if (ph == 4) begin
            ph   = 0;
            tick = 1'b1;
            hc_p = 11'(hcnt);
            vc_p = 11'(vcnt);
            p    = pix_of(hcnt, vcnt);
            rgb  = (hcnt < H && vcnt < V) ? p : 12'hBAD;
            if (ms == 1 && hcnt == 0 && vcnt == 0) ms = 2;
            if (ms == 2 && hcnt < H && vcnt < V) begin
                eof = (hcnt == H - 1 && vcnt == V - 1);
                // Hold register absorbs one pixel ahead of the FIFO.
                if (!ovf_mode || eof || acc < DEPTH + 1) begin
                    sb.push_back({1'b0, p[7:0]});
                    sb.push_back({eof, 4'h0, p[11:8]});
                    acc++;
                end
                if (eof) ms = 3;
            end
            hcnt = hcnt + 1;
            if (hcnt == HT) begin
                hcnt = 0;
                vcnt = vcnt + 1;
                if (vcnt == VT) vcnt = 0;
            end
        end
        if (st && ms == 0) begin
            ms  = 1;
            acc = 0;
        end
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while (!(ms == 3 && sb.size() == 0) && n < budget) begin
            cycle(0);
            n++;
        end
        chk({tag, "_drain_timeout"}, 32'(n < budget), 1);
        repeat (3) cycle(0);
        ms = 0;
    endtask

    task automatic clr_cnt();
        nbytes = 0;
        nlast  = 0;
        ndone  = 0;
    endtask

    initial forever begin
        logic [8:0] exp;
        @(negedge clk);
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 32'(axis.M_AXIS_VALID), 1);
                chk("stall_data", 32'(axis.M_AXIS_DATA), 32'(prev_data));
                chk("stall_last", 32'(axis.M_AXIS_LAST), 32'(prev_last));
            end
            if (axis.M_AXIS_VALID && axis.M_AXIS_READY) begin
                nchk++;
                assert (sb.size() > 0) else begin
                    nerr++;
                    $error("FAIL unexpected_byte: got %0h expected none",
                           {axis.M_AXIS_LAST, axis.M_AXIS_DATA});
                end
                if (sb.size() > 0) begin
                    exp = sb.pop_front();
                    chk("byte", 32'({axis.M_AXIS_LAST, axis.M_AXIS_DATA}),
                        32'(exp));
                end
                if (nbytes == 0) first_b = axis.M_AXIS_DATA;
                nbytes++;
                if (axis.M_AXIS_LAST) nlast++;
            end
            if (fdone) ndone++;
            prev_stall = axis.M_AXIS_VALID && !axis.M_AXIS_READY;
            prev_data  = axis.M_AXIS_DATA;
            prev_last  = axis.M_AXIS_LAST;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        axis.M_AXIS_READY = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(axis.M_AXIS_VALID), 0);
        chk("rst_last", 32'(axis.M_AXIS_LAST), 0);
        chk("rst_data", 32'(axis.M_AXIS_DATA), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(fdone), 0);
        chk("rst_ovf", 32'(ovf), 0);
        rst = 1'b0;

        // Full-rate frame
        rmode = 1;
        clr_cnt();
        repeat (2) cycle(0);
        cycle(1);
        cycle(0);
        chk("A_busy_start", 32'(busy), 1);
        drain("A", 2000);
        chk("A_bytes", nbytes, 2 * H * V);
        chk("A_first", 32'(first_b), 32'h5C);
        chk("A_last", nlast, 1);
        chk("A_done", ndone, 1);
        chk("A_busy_end", 32'(busy), 0);
        chk("A_ovf", 32'(ovf), 0);

        // Stalling sink, start mid-frame, second start while capturing
        rmode = 2;
        clr_cnt();
        n = 0;
        while (!(hcnt == 5 && vcnt == 1) && n < 1000) begin
            cycle(0);
            n++;
        end
        cycle(1);
        n = 0;
        while (!(ms == 2 && hcnt == 3) && n < 1000) begin
            cycle(0);
            n++;
        end
        chk("B_capturing", ms, 2);
        cycle(1);
        drain("B", 3000);
        chk("B_bytes", nbytes, 2 * H * V);
        chk("B_first", 32'(first_b), 32'h5C);
        chk("B_last", nlast, 1);
        chk("B_done", ndone, 1);
        chk("B_ovf", 32'(ovf), 0);
        chk("B_busy_end", 32'(busy), 0);

        // Sink blocked for the whole frame
        rmode = 0;
        ovf_mode = 1;
        clr_cnt();
        cycle(1);
        n = 0;
        while (ms != 3 && n < 1000) begin
            cycle(0);
            n++;
        end
        chk("C_reach_eof", ms, 3);
        repeat (8) cycle(0);
        chk("C_ovf_set", 32'(ovf), 1);
        chk("C_no_bytes", nbytes, 0);
        chk("C_valid_held", 32'(axis.M_AXIS_VALID), 1);
        chk("C_busy", 32'(busy), 1);
        rmode = 1;
        drain("C", 2000);
        ovf_mode = 0;
        chk("C_bytes", nbytes, 2 * (DEPTH + 2));
        chk("C_last", nlast, 1);
        chk("C_done", ndone, 1);
        chk("C_ovf_sticky", 32'(ovf), 1);

        // Reset in the middle of a transfer
        rmode = 1;
        clr_cnt();
        cycle(1);
        cycle(0);
        chk("D_ovf_cleared", 32'(ovf), 0);
        n = 0;
        while (nbytes < 20 && n < 2000) begin
            cycle(0);
            n++;
        end
        chk("D_reach_20", 32'(nbytes >= 20), 1);
        chk("D_no_last_yet", nlast, 0);
        rst = 1'b1;
        #1;
        chk("D_async_valid", 32'(axis.M_AXIS_VALID), 0);
        chk("D_async_last", 32'(axis.M_AXIS_LAST), 0);
        chk("D_async_data", 32'(axis.M_AXIS_DATA), 0);
        chk("D_async_busy", 32'(busy), 0);
        sb.delete();
        ms = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("D_aborted_last", nlast, 0);
        clr_cnt();
        repeat (3) cycle(0);
        chk("D_idle_no_bytes", nbytes, 0);
        cycle(1);
        drain("D", 2000);
        chk("D_bytes", nbytes, 2 * H * V);
        chk("D_first", 32'(first_b), 32'h5C);
        chk("D_last", nlast, 1);
        chk("D_done", ndone, 1);
        chk("D_busy_end", 32'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
        $finish;
    end

endmodule
